// File: rtl/spi_byte_phy.sv
// Byte-level SPI master shifter (CPOL=0, CPHA=1) feeding an ADS1256-class ADC.
// Shifts one byte out on DIN MSB-first while sampling DOUT through a synchronizer.
module spi_byte_phy #(
  parameter int HALF_PERIOD = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       spi_start_i,
  input  logic [7:0] tx_buffer_i,
  output logic       spi_done_o,
  output logic [7:0] rx_byte_o,
  output logic       busy_o,
  output logic       SCLK_o,
  output logic       DIN_o,
  input  logic       DOUT_i
);

  generate
    if (HALF_PERIOD < 3 || HALF_PERIOD > 255) begin : g_half_period_check
      $fatal(1, "spi_byte_phy: HALF_PERIOD must be within 3..255");
    end
    if (SYNC_STAGES < 1) begin : g_sync_stages_check
      $fatal(1, "spi_byte_phy: SYNC_STAGES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

  state_t                 state, state_n;
  logic [7:0]             half_cnt, half_cnt_n;
  logic [2:0]             bit_cnt, bit_cnt_n;
  logic [7:0]             tx_sr, tx_sr_n;
  logic [7:0]             rx_sr, rx_sr_n;
  logic [7:0]             rx_byte_n;
  logic                   din_n;
  logic [SYNC_STAGES-1:0] dout_sync;
  logic                   dout_s;

  assign dout_s = dout_sync[SYNC_STAGES-1];

  // DOUT is asynchronous to clock_i; HALF_PERIOD >= 3 covers this delay.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      dout_sync <= '0;
    end else begin
      dout_sync[0] <= DOUT_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        dout_sync[i] <= dout_sync[i-1];
      end
    end
  end

  always_comb begin
    state_n    = state;
    half_cnt_n = half_cnt;
    bit_cnt_n  = bit_cnt;
    tx_sr_n    = tx_sr;
    rx_sr_n    = rx_sr;
    rx_byte_n  = rx_byte_o;
    din_n      = DIN_o;
    case (state)
      IDLE, DONE: begin
        // DONE also accepts so a start asserted off spi_done chains with no gap.
        state_n = IDLE;
        din_n   = 1'b0;
        if (spi_start_i) begin
          state_n    = HIGH;
          tx_sr_n    = tx_buffer_i;
          din_n      = tx_buffer_i[7];
          bit_cnt_n  = 3'd0;
          half_cnt_n = 8'd0;
        end
      end
      HIGH: begin
        if (half_cnt == HP_LAST) begin
          state_n    = LOW;
          half_cnt_n = 8'd0;
          rx_sr_n    = {rx_sr[6:0], dout_s};
        end else begin
          half_cnt_n = half_cnt + 8'd1;
        end
      end
      LOW: begin
        if (half_cnt == HP_LAST) begin
          half_cnt_n = 8'd0;
          if (bit_cnt == 3'd7) begin
            state_n   = DONE;
            rx_byte_n = rx_sr;
            din_n     = 1'b0;
          end else begin
            state_n   = HIGH;
            bit_cnt_n = bit_cnt + 3'd1;
            tx_sr_n   = {tx_sr[6:0], 1'b0};
            din_n     = tx_sr[6];
          end
        end else begin
          half_cnt_n = half_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Every pin is registered off the next state so SCLK stays glitch-free.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      half_cnt   <= 8'd0;
      bit_cnt    <= 3'd0;
      tx_sr      <= 8'd0;
      rx_sr      <= 8'd0;
      rx_byte_o  <= 8'd0;
      DIN_o      <= 1'b0;
      SCLK_o     <= 1'b0;
      busy_o     <= 1'b0;
      spi_done_o <= 1'b0;
    end else begin
      state      <= state_n;
      half_cnt   <= half_cnt_n;
      bit_cnt    <= bit_cnt_n;
      tx_sr      <= tx_sr_n;
      rx_sr      <= rx_sr_n;
      rx_byte_o  <= rx_byte_n;
      DIN_o      <= din_n;
      SCLK_o     <= (state_n == HIGH);
      busy_o     <= (state_n == HIGH) || (state_n == LOW);
      spi_done_o <= (state_n == DONE);
    end
  end

endmodule

// File: doc/spi_byte_phy.md
Name: spi_byte_phy

Overview:
- Byte-level SPI master shifter that sits directly downstream of spi_transaction_layer.
- Consumes spi_start / tx_buffer from the transaction layer and drives SCLK and DIN to the ADS1256-class ADC.
- Samples DOUT from the ADC and returns the received byte with a single-cycle done pulse.
- Chip select is owned by the transaction layer and is not handled here; this block only clocks bytes.

Parameters:
- HALF_PERIOD, 4: system clock cycles per SCLK half-period. Legal range is 3..255; elaboration fails (fatal) if HALF_PERIOD < 3.
- SYNC_STAGES, 2: number of flops in the DOUT_i synchronizer. Fixed at 2 for now; kept as a parameter for timing closure.

Ports:
- clock_i  in  1  system clock; all logic on its rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- spi_start_i  in  1  start request; level-sampled; accepted only in IDLE or DONE.
- tx_buffer_i  in  8  byte to transmit; captured on the accepting edge.
- spi_done_o  out  1  one-cycle pulse; the byte is complete.
- rx_byte_o  out  8  received byte; updated in the spi_done_o cycle, held until the next done.
- busy_o  out  1  high from the accept edge until the DONE cycle (exclusive).
- SCLK_o  out  1  SPI clock. CPOL=0, CPHA=1: DIN changes on the rising edge, DOUT is sampled on the falling edge.
- DIN_o  out  1  serial data to the ADC, MSB first.
- DOUT_i  in  1  serial data from the ADC (asynchronous); passed through the synchronizer.

Behaviour:
- Reset state (asynchronous, immediate):
  - state = IDLE.
  - SCLK_o, DIN_o, spi_done_o and busy_o = 0.
  - rx_byte_o, the shift registers, the half-period counter and the bit counter = 0.
- States: IDLE, HIGH, LOW, DONE.
- Accepting a start:
  - If spi_start_i = 1 at the edge ending cycle N while in IDLE or DONE, the block latches tx_buffer_i into tx_sr.
  - In cycle N+1: state = HIGH, SCLK_o = 1, DIN_o = tx_sr[7], busy_o = 1, bit_cnt = 0, half_cnt = 0.
- HIGH phase: lasts HALF_PERIOD cycles. On its final edge:
  - state goes to LOW and SCLK_o = 0.
  - The synchronized DOUT is shifted into rx_sr LSB (MSB-first receive).
- LOW phase: lasts HALF_PERIOD cycles; DIN_o holds. On its final edge:
  - If bit_cnt < 7: bit_cnt increments, state goes to HIGH, SCLK_o = 1, DIN_o = the next tx bit.
  - If bit_cnt = 7: state goes to DONE.
- DONE lasts exactly one cycle:
  - spi_done_o = 1, rx_byte_o = rx_sr, busy_o = 0, DIN_o = 0, SCLK_o = 0.
  - If spi_start_i = 1 in DONE, the next byte starts immediately (HIGH in the next cycle). This is required because the transaction layer asserts its next spi_start combinationally off spi_done.
  - Otherwise the block returns to IDLE.
- Latency: spi_done_o is high in cycle N + 16*HALF_PERIOD + 1 (cycle N+65 at default). Exactly 8 SCLK rising edges occur per byte.
- spi_start_i while in HIGH or LOW: ignored. No queuing, no effect on the in-flight byte, and tx_buffer_i changes are ignored.
- Held start: if spi_start_i is held high across IDLE, one byte is issued per accept. A start held high through DONE chains bytes back-to-back with no idle gap.
- SCLK timing:
  - SCLK_o is glitch-free and driven directly from a flop.
  - SCLK idles low whenever not in HIGH.
  - Minimum high/low width is HALF_PERIOD clocks.
- DOUT sampling margin: the synchronizer delays DOUT by 2 cycles. The ADC changes DOUT on the rising edge, so HALF_PERIOD >= 3 guarantees the sampled bit is the one launched by the preceding rising edge.
- Reset mid-transfer: all outputs return to their reset values immediately and no spi_done_o pulse is produced. After reset release, the next start begins a fresh byte.

Test Plan:
- Single byte, default params: tx_buffer_i = 0xA5, ADC model shifting 0x3C on SCLK rising edges, start pulsed in cycle N.
  - Exactly 8 SCLK rises.
  - DIN bits 1,0,1,0,0,1,0,1.
  - spi_done_o pulses once in cycle N+65 with rx_byte_o = 0x3C; busy_o high N+1..N+64.
- Back-to-back: start held high through DONE with tx 0x17 then 0x00; DOUT model returns 0x81 then 0x7E.
  - The second byte's first SCLK rise is in the cycle after done.
  - Two done pulses 65 cycles apart; rx_byte_o = 0x81 then 0x7E.
- Start while busy: pulse start again with tx 0xFF at cycle N+20 of a 0x0F transfer.
  - DIN pattern remains 0x0F.
  - Only one done pulse; the block returns to IDLE.
- Reset mid-transfer: assert reset_i in cycle N+30.
  - SCLK_o, DIN_o and busy_o go to 0 the same cycle; rx_byte_o = 0; no done pulse.
  - A later start with 0x55 / DOUT 0xAA completes with rx_byte_o = 0xAA.
- HALF_PERIOD = 3 override: tx 0xC3, DOUT 0x5A.
  - done in cycle N+49; rx_byte_o = 0x5A.
  - SCLK high and low widths are exactly 3 clocks.
- HALF_PERIOD = 2: elaboration fails with a fatal error.
